// File: rtl/sync_fifo_param_pkg.sv
// Shared constants and sizing helper for the single-clock parametrised FIFO.
// Pointer and count widths are derived from DEPTH through clog2.
package sync_fifo_param_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 16;

  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Simple dual-port RAM: synchronous write port, asynchronous read port.
// Contents are never reset; the FIFO pointers decide what is meaningful.
module fifo_dpram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with standard or first-word-fall-through read mode,
// programmable almost-full/almost-empty thresholds and error pulses.
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 4,
  parameter int FWFT      = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      rd_valid,
  output logic                      fifo_full,
  output logic                      fifo_empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [clog2(DEPTH):0]     fill_cnt,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]    wrPtr_q, wrPtr_d;
  logic [CW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             overflow_q, underflow_q;
  logic             wrAccept, rdAccept;
  logic [WIDTH-1:0] memRdata;

  assign wrAccept = wr_en && !fifo_full;
  assign rdAccept = rd_en && !fifo_empty;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    cnt_d   = cnt_q;
    if (wrAccept) wrPtr_d = wrPtr_q + CW'(1);
    if (rdAccept) rdPtr_d = rdPtr_q + CW'(1);
    case ({wrAccept, rdAccept})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // A rejected request only raises its error pulse; no other state moves.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      cnt_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      cnt_q       <= cnt_d;
      overflow_q  <= wr_en && fifo_full;
      underflow_q <= rd_en && fifo_empty;
    end
  end

  assign fill_cnt     = cnt_q;
  assign fifo_full    = (cnt_q == CW'(DEPTH));
  assign fifo_empty   = (cnt_q == '0);
  assign almost_full  = (cnt_q >= CW'(AF_THRESH));
  assign almost_empty = (cnt_q <= CW'(AE_THRESH));
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  fifo_dpram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wrAccept),
    .waddr_i (wrPtr_q[AW-1:0]),
    .wdata_i (wr_data),
    .raddr_i (rdPtr_q[AW-1:0]),
    .rdata_o (memRdata)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data  = memRdata;
      assign rd_valid = !fifo_empty;
    end else begin : g_std
      logic [WIDTH-1:0] rdData_q;
      logic             rdValid_q;

      // Registered read: data is captured on the accepted read and held otherwise.
      always_ff @(posedge clk) begin
        if (rst) begin
          rdData_q  <= '0;
          rdValid_q <= 1'b0;
        end else begin
          rdValid_q <= rdAccept;
          if (rdAccept) rdData_q <= memRdata;
        end
      end

      assign rd_data  = rdData_q;
      assign rd_valid = rdValid_q;
    end
  endgenerate

endmodule
